panda_risc_v_dispatch_ctrl: RTL and testbench
=============================================

PANDA_RISC_V_DISPATCH_CTRL -- requirements
Module: panda_risc_v_dispatch_ctrl

Interface
REQ-001 SHALL have parameter PLD_W, default 128: width of the opaque decoded-payload bus, forwarded unchanged to the execution units.
REQ-002 SHALL have ports: clk  in  1  system clock; sys_rst  in  1  reset.
- One clock.
- Reset is synchronous and active-high.
REQ-003 SHALL have decode-side input ports (valid/ready handshake):
- s_dcd_valid  in  1
- s_dcd_ready  out  1
- s_dcd_pld  in  PLD_W  payload
- s_dcd_type  in  7  {is_b, is_csr_rw, is_load, is_store, is_mul, is_div, is_rem}
- s_dcd_rs1_id/rs2_id/rd_id  in  5 each
- s_dcd_rs1_vld/rs2_vld/rd_vld  in  1 each
REQ-004 SHALL have, for each unit U in {alu, lsu, csr, mul, div}, ports m_U_valid out 1, m_U_ready in 1; plus m_pld out PLD_W, shared by all units.
REQ-005 SHALL have write-back ports lsu_wb_vld in 1, lsu_wb_rd in 5, md_wb_vld in 1, md_wb_rd in 5, flush in 1, and pending_vec out 32 (scoreboard).

Function
REQ-006 SHALL hold one instruction in a register, using a 2-state FSM EMPTY/FULL.
REQ-007 SHALL assert s_dcd_ready = EMPTY | issue_fire, where issue_fire is the handshake on the selected unit; this allows one accept per cycle back-to-back.
REQ-008 SHALL select the target unit from the held type:
- load|store -> lsu
- csr_rw -> csr
- mul -> mul
- div|rem -> div
- otherwise (including is_b) -> alu
REQ-009 SHALL assert exactly one m_U_valid, and only when FULL & ~hazard; m_U_valid SHALL stay asserted with m_pld stable until m_U_ready or flush.
REQ-010 SHALL define hazard = (rs1_vld & pend[rs1]) | (rs2_vld & pend[rs2]) | (rd_vld & pend[rd]), with index 0 never pending.
REQ-011 SHALL give minimum latency of one cycle: accepted in cycle N, m_U_valid in N+1 when there is no hazard.
REQ-012 SHALL set pend[rd] on issue_fire of a load, mul, div or rem with rd_vld and rd != 0.
REQ-013 SHALL clear pend[lsu_wb_rd] when lsu_wb_vld is high and pend[md_wb_rd] when md_wb_vld is high; both clears in one cycle are allowed.
REQ-014 SHALL let set win over clear when both hit the same register in the same cycle.
REQ-015 SHALL, on flush, go to EMPTY the next cycle, drop the held instruction, deassert all m_U_valid, and hold s_dcd_ready low during the flush cycle; flush SHALL NOT alter the scoreboard (in-flight ops still write back).
REQ-016 SHALL give flush priority over a simultaneous accept or issue: nothing is accepted and the scoreboard is not set.
REQ-017 SHALL drive pending_vec = pend, with bit 0 constant 0.

Reset
REQ-018 SHALL, on sys_rst at any clk edge (including mid-stall), set FSM=EMPTY, pend=0, all m_U_valid=0, s_dcd_ready=0 during reset and 1 on the first cycle after, and m_pld=0.

Configuration
REQ-019 SHALL support macro PANDA_RISC_V_DSPT_WB_FWD_EN.
- Defined: hazard evaluation SHALL treat a register being cleared by a write-back this cycle as not pending, so issue occurs in the write-back cycle.
- Undefined: issue occurs no earlier than the cycle after write-back.

Structure
REQ-020 SHALL place the unit-select encoding, the inst-type bit indices (rem=0 ... b=6, same order as the decoder's packed type) and the default PLD_W in a shared package, panda_risc_v_dspt_pkg.
REQ-021 SHALL implement the scoreboard as one sub-module, panda_risc_v_dspt_scoreboard, handling set/clear/lookup of 32 pending bits.

Verification
REQ-022 Bench SHALL cover: ADD (type 0, rd=5) with alu_ready=1 -> m_alu_valid one cycle after accept, pend stays 0.
REQ-023 Bench SHALL cover: LW rd=7, then ADD rs1=7 -> ADD stalls; lsu_wb_vld with rd=7 -> ADD issues in the same cycle with FWD_EN defined, and one cycle later without it.
REQ-024 Bench SHALL cover: DIV rd=3 issue, then MUL rd=3 -> WAW stall until md_wb_rd=3; pending_vec=0x8 during the stall.
REQ-025 Bench SHALL cover: held CSR with csr_ready=0 for 4 cycles, flush in cycle 3 -> m_csr_valid drops, FSM EMPTY, no csr handshake.
REQ-026 Bench SHALL cover: LW rd=0 -> pend unchanged (0); simultaneous lsu_wb and md_wb on rd 4 and 9 -> both bits cleared.
REQ-027 Bench SHALL cover: sys_rst asserted while stalled with pend=0xF0 -> next cycle pend=0, all valids 0.

Source files
------------

// File: rtl/panda_risc_v_dspt_pkg.sv
// Shared definitions for the dispatch controller: instruction-type bit
// positions (same order as the decoder's packed type), unit-select encoding
// and the default payload width.
package panda_risc_v_dspt_pkg;

    localparam int DSPT_PLD_W_DEF = 128;

    localparam int INST_TYPE_W      = 7;
    localparam int INST_TYPE_REM    = 0;
    localparam int INST_TYPE_DIV    = 1;
    localparam int INST_TYPE_MUL    = 2;
    localparam int INST_TYPE_STORE  = 3;
    localparam int INST_TYPE_LOAD   = 4;
    localparam int INST_TYPE_CSR_RW = 5;
    localparam int INST_TYPE_B      = 6;

    typedef enum logic [2:0] {
        UNIT_ALU = 3'd0,
        UNIT_LSU = 3'd1,
        UNIT_CSR = 3'd2,
        UNIT_MUL = 3'd3,
        UNIT_DIV = 3'd4
    } dspt_unit_e;

    typedef enum logic {
        DSPT_EMPTY = 1'b0,
        DSPT_FULL  = 1'b1
    } dspt_state_e;

    // Target unit for a packed instruction type; branches fall through to ALU.
    function automatic dspt_unit_e dspt_unit_of(input logic [INST_TYPE_W-1:0] t);
        if (t[INST_TYPE_LOAD] | t[INST_TYPE_STORE])
            return UNIT_LSU;
        else if (t[INST_TYPE_CSR_RW])
            return UNIT_CSR;
        else if (t[INST_TYPE_MUL])
            return UNIT_MUL;
        else if (t[INST_TYPE_DIV] | t[INST_TYPE_REM])
            return UNIT_DIV;
        else
            return UNIT_ALU;
    endfunction

    // Long-latency ops whose destination must be tracked until write-back.
    function automatic logic dspt_tracks_rd(input logic [INST_TYPE_W-1:0] t);
        return t[INST_TYPE_LOAD] | t[INST_TYPE_MUL] | t[INST_TYPE_DIV] | t[INST_TYPE_REM];
    endfunction

endpackage

// File: rtl/panda_risc_v_dispatch_ctrl_if.sv
// Dispatch controller bus: decode-side handshake, per-unit issue handshakes,
// shared payload, write-back notifications and the scoreboard view.
// slave = the dispatch controller, master = its surroundings.
interface panda_risc_v_dispatch_ctrl_if
    import panda_risc_v_dspt_pkg::*;
#(
    parameter int PLD_W = DSPT_PLD_W_DEF
);
    logic             s_dcd_valid;
    logic             s_dcd_ready;
    logic [PLD_W-1:0] s_dcd_pld;
    logic [6:0]       s_dcd_type;
    logic [4:0]       s_dcd_rs1_id;
    logic [4:0]       s_dcd_rs2_id;
    logic [4:0]       s_dcd_rd_id;
    logic             s_dcd_rs1_vld;
    logic             s_dcd_rs2_vld;
    logic             s_dcd_rd_vld;

    logic             m_alu_valid;
    logic             m_alu_ready;
    logic             m_lsu_valid;
    logic             m_lsu_ready;
    logic             m_csr_valid;
    logic             m_csr_ready;
    logic             m_mul_valid;
    logic             m_mul_ready;
    logic             m_div_valid;
    logic             m_div_ready;
    logic [PLD_W-1:0] m_pld;

    logic             lsu_wb_vld;
    logic [4:0]       lsu_wb_rd;
    logic             md_wb_vld;
    logic [4:0]       md_wb_rd;
    logic             flush;
    logic [31:0]      pending_vec;

    modport slave (
        input  s_dcd_valid, s_dcd_pld, s_dcd_type,
               s_dcd_rs1_id, s_dcd_rs2_id, s_dcd_rd_id,
               s_dcd_rs1_vld, s_dcd_rs2_vld, s_dcd_rd_vld,
               m_alu_ready, m_lsu_ready, m_csr_ready, m_mul_ready, m_div_ready,
               lsu_wb_vld, lsu_wb_rd, md_wb_vld, md_wb_rd, flush,
        output s_dcd_ready,
               m_alu_valid, m_lsu_valid, m_csr_valid, m_mul_valid, m_div_valid,
               m_pld, pending_vec
    );

    modport master (
        output s_dcd_valid, s_dcd_pld, s_dcd_type,
               s_dcd_rs1_id, s_dcd_rs2_id, s_dcd_rd_id,
               s_dcd_rs1_vld, s_dcd_rs2_vld, s_dcd_rd_vld,
               m_alu_ready, m_lsu_ready, m_csr_ready, m_mul_ready, m_div_ready,
               lsu_wb_vld, lsu_wb_rd, md_wb_vld, md_wb_rd, flush,
        input  s_dcd_ready,
               m_alu_valid, m_lsu_valid, m_csr_valid, m_mul_valid, m_div_valid,
               m_pld, pending_vec
    );

endinterface

// File: rtl/panda_risc_v_dspt_scoreboard.sv
// 32-entry pending-destination scoreboard with one set port, two clear ports
// and a three-operand hazard lookup. x0 is never pending.
// Optional: PANDA_RISC_V_DSPT_WB_FWD_EN makes a register being cleared this
// cycle look free to the lookup, so a waiting op can issue in the write-back
// cycle itself.
module panda_risc_v_dspt_scoreboard (
    input  logic        clk,
    input  logic        sys_rst,
    input  logic        set_vld,
    input  logic [4:0]  set_rd,
    input  logic        clr0_vld,
    input  logic [4:0]  clr0_rd,
    input  logic        clr1_vld,
    input  logic [4:0]  clr1_rd,
    input  logic        rs1_vld,
    input  logic [4:0]  rs1_id,
    input  logic        rs2_vld,
    input  logic [4:0]  rs2_id,
    input  logic        rd_vld,
    input  logic [4:0]  rd_id,
    output logic        hazard,
    output logic [31:0] pend_vec
);
    logic [31:0] pend_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] look_mask;

    // Decode set/clear ports into masks and evaluate the operand hazard.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld)
            set_mask[set_rd] = 1'b1;
        if (clr0_vld)
            clr_mask[clr0_rd] = 1'b1;
        if (clr1_vld)
            clr_mask[clr1_rd] = 1'b1;
`ifdef PANDA_RISC_V_DSPT_WB_FWD_EN
        look_mask = pend_q & ~clr_mask;
`else
        look_mask = pend_q;
`endif
        hazard = (rs1_vld & look_mask[rs1_id])
               | (rs2_vld & look_mask[rs2_id])
               | (rd_vld  & look_mask[rd_id]);
    end

    // Clear first, then set, so a re-issue to the same rd stays pending.
    always_ff @(posedge clk) begin
        if (sys_rst)
            pend_q <= '0;
        else
            pend_q <= ((pend_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
    end

    assign pend_vec = pend_q;

endmodule

// File: rtl/panda_risc_v_dispatch_ctrl.sv
// Single-entry dispatch stage: holds one decoded instruction, routes it to
// ALU/LSU/CSR/MUL/DIV once its operands and destination are free, and tracks
// outstanding long-latency destinations in a scoreboard.
// Optional: PANDA_RISC_V_DSPT_WB_FWD_EN (handled in the scoreboard) lets an
// op issue in the same cycle as the write-back it waits for.
//
// state      | meaning
// DSPT_EMPTY | no instruction held, decode side may hand one over
// DSPT_FULL  | instruction held, waiting for hazards to clear and unit ready
module panda_risc_v_dispatch_ctrl
    import panda_risc_v_dspt_pkg::*;
#(
    parameter int PLD_W = DSPT_PLD_W_DEF
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    panda_risc_v_dispatch_ctrl_if.slave  bus
);
    dspt_state_e      state_q;
    logic [PLD_W-1:0] pld_q;
    logic [6:0]       type_q;
    logic [4:0]       rs1_id_q;
    logic [4:0]       rs2_id_q;
    logic [4:0]       rd_id_q;
    logic             rs1_vld_q;
    logic             rs2_vld_q;
    logic             rd_vld_q;

    dspt_unit_e       unit_sel;
    logic             hazard;
    logic             issue_vld;
    logic             unit_ready;
    logic             issue_fire;
    logic             dcd_ready;
    logic             accept;
    logic             sb_set;

    panda_risc_v_dspt_scoreboard u_scoreboard (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .set_vld  (sb_set),
        .set_rd   (rd_id_q),
        .clr0_vld (bus.lsu_wb_vld),
        .clr0_rd  (bus.lsu_wb_rd),
        .clr1_vld (bus.md_wb_vld),
        .clr1_rd  (bus.md_wb_rd),
        .rs1_vld  (rs1_vld_q),
        .rs1_id   (rs1_id_q),
        .rs2_vld  (rs2_vld_q),
        .rs2_id   (rs2_id_q),
        .rd_vld   (rd_vld_q),
        .rd_id    (rd_id_q),
        .hazard   (hazard),
        .pend_vec (bus.pending_vec)
    );

    // Issue decision: flush and reset suppress both issue and accept, so
    // neither the held entry nor the scoreboard can change under them.
    always_comb begin
        unit_sel  = dspt_unit_of(type_q);
        issue_vld = (state_q == DSPT_FULL) & ~hazard & ~bus.flush & ~sys_rst;
        unit_ready = 1'b0;
        case (unit_sel)
            UNIT_ALU: unit_ready = bus.m_alu_ready;
            UNIT_LSU: unit_ready = bus.m_lsu_ready;
            UNIT_CSR: unit_ready = bus.m_csr_ready;
            UNIT_MUL: unit_ready = bus.m_mul_ready;
            UNIT_DIV: unit_ready = bus.m_div_ready;
            default:  unit_ready = 1'b0;
        endcase
        issue_fire = issue_vld & unit_ready;
        dcd_ready  = ~sys_rst & ~bus.flush & ((state_q == DSPT_EMPTY) | issue_fire);
        accept     = bus.s_dcd_valid & dcd_ready;
        sb_set     = issue_fire & dspt_tracks_rd(type_q) & rd_vld_q & (rd_id_q != 5'd0);
    end

    assign bus.s_dcd_ready = dcd_ready;
    assign bus.m_alu_valid = issue_vld & (unit_sel == UNIT_ALU);
    assign bus.m_lsu_valid = issue_vld & (unit_sel == UNIT_LSU);
    assign bus.m_csr_valid = issue_vld & (unit_sel == UNIT_CSR);
    assign bus.m_mul_valid = issue_vld & (unit_sel == UNIT_MUL);
    assign bus.m_div_valid = issue_vld & (unit_sel == UNIT_DIV);
    assign bus.m_pld       = pld_q;

    // Holding-register FSM; an accept in FULL is a back-to-back replace.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q   <= DSPT_EMPTY;
            pld_q     <= '0;
            type_q    <= '0;
            rs1_id_q  <= '0;
            rs2_id_q  <= '0;
            rd_id_q   <= '0;
            rs1_vld_q <= 1'b0;
            rs2_vld_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            if (accept) begin
                pld_q     <= bus.s_dcd_pld;
                type_q    <= bus.s_dcd_type;
                rs1_id_q  <= bus.s_dcd_rs1_id;
                rs2_id_q  <= bus.s_dcd_rs2_id;
                rd_id_q   <= bus.s_dcd_rd_id;
                rs1_vld_q <= bus.s_dcd_rs1_vld;
                rs2_vld_q <= bus.s_dcd_rs2_vld;
                rd_vld_q  <= bus.s_dcd_rd_vld;
            end
            case (state_q)
                DSPT_EMPTY: begin
                    if (accept)
                        state_q <= DSPT_FULL;
                end
                DSPT_FULL: begin
                    if (bus.flush)
                        state_q <= DSPT_EMPTY;
                    else if (!accept && issue_fire)
                        state_q <= DSPT_EMPTY;
                end
                default: state_q <= DSPT_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_panda_risc_v_dispatch_ctrl.sv
// Self-checking bench for panda_risc_v_dispatch_ctrl: directed scenarios plus
// a randomized run against a rule-level reference model.
module tb_panda_risc_v_dispatch_ctrl;

`ifdef PANDA_RISC_V_DSPT_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [6:0] T_ADD = 7'b0000000;
    localparam logic [6:0] T_LW  = 7'b0010000;
    localparam logic [6:0] T_CSR = 7'b0100000;
    localparam logic [6:0] T_MUL = 7'b0000100;
    localparam logic [6:0] T_DIV = 7'b0000010;

    // valid vector order {div, mul, csr, lsu, alu}
    localparam logic [4:0] V_NONE = 5'b00000;
    localparam logic [4:0] V_ALU  = 5'b00001;
    localparam logic [4:0] V_LSU  = 5'b00010;
    localparam logic [4:0] V_CSR  = 5'b00100;
    localparam logic [4:0] V_MUL  = 5'b01000;
    localparam logic [4:0] V_DIV  = 5'b10000;

    logic clk;
    logic sys_rst;
    int   n_cmp = 0;
    int   n_err = 0;

    panda_risc_v_dispatch_ctrl_if #(.PLD_W(128)) bus ();

    panda_risc_v_dispatch_ctrl #(.PLD_W(128)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [4:0] valids();
        return {bus.m_div_valid, bus.m_mul_valid, bus.m_csr_valid, bus.m_lsu_valid, bus.m_alu_valid};
    endfunction

    function automatic logic [4:0] unit_of(input logic [6:0] t);
        if (t[4] || t[3]) return V_LSU;
        if (t[5])         return V_CSR;
        if (t[2])         return V_MUL;
        if (t[1] || t[0]) return V_DIV;
        return V_ALU;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.s_dcd_valid = 1'b0;  bus.s_dcd_pld = '0;     bus.s_dcd_type = '0;
        bus.s_dcd_rs1_id = '0;   bus.s_dcd_rs2_id = '0;  bus.s_dcd_rd_id = '0;
        bus.s_dcd_rs1_vld = 1'b0; bus.s_dcd_rs2_vld = 1'b0; bus.s_dcd_rd_vld = 1'b0;
        bus.m_alu_ready = 1'b1;  bus.m_lsu_ready = 1'b1; bus.m_csr_ready = 1'b1;
        bus.m_mul_ready = 1'b1;  bus.m_div_ready = 1'b1;
        bus.lsu_wb_vld = 1'b0;   bus.lsu_wb_rd = '0;
        bus.md_wb_vld = 1'b0;    bus.md_wb_rd = '0;
        bus.flush = 1'b0;
    endtask

    task automatic present(input logic [6:0] t, input logic [4:0] rs1, input logic rs1v,
                           input logic [4:0] rd, input logic rdv, input logic [127:0] pld);
        bus.s_dcd_valid = 1'b1;  bus.s_dcd_type = t;     bus.s_dcd_pld = pld;
        bus.s_dcd_rs1_id = rs1;  bus.s_dcd_rs1_vld = rs1v;
        bus.s_dcd_rs2_id = 5'd0; bus.s_dcd_rs2_vld = 1'b0;
        bus.s_dcd_rd_id = rd;    bus.s_dcd_rd_vld = rdv;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        idle_inputs();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        idle_inputs();
        tick(); tick();
        n_cmp++; if (bus.s_dcd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.s_dcd_ready); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL rst_valids: got %b want %b", valids(), V_NONE); end
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL rst_pend: got %h want 0", bus.pending_vec); end
        n_cmp++; if (bus.m_pld !== 128'h0) begin n_err++; $display("FAIL rst_pld: got %h want 0", bus.m_pld); end
        sys_rst = 1'b0;
        #1;
        n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after: got %b want 1", bus.s_dcd_ready); end
    endtask

    task automatic test_alu();
        do_reset();
        present(T_ADD, 5'd0, 1'b0, 5'd5, 1'b1, 128'h1234_5678_9ABC);
        #1;
        n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL alu_accept: got %b want 1", bus.s_dcd_ready); end
        tick();
        bus.s_dcd_valid = 1'b0;
        #1;
        n_cmp++; if (valids() !== V_ALU) begin n_err++; $display("FAIL alu_issue: got %b want %b", valids(), V_ALU); end
        n_cmp++; if (bus.m_pld !== 128'h1234_5678_9ABC) begin n_err++; $display("FAIL alu_pld: got %h want 123456789abc", bus.m_pld); end
        tick();
        #1;
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL alu_pend: got %h want 0", bus.pending_vec); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL alu_done: got %b want %b", valids(), V_NONE); end
    endtask

    task automatic test_raw_stall();
        do_reset();
        present(T_LW, 5'd0, 1'b0, 5'd7, 1'b1, 128'h11);
        tick();
        present(T_ADD, 5'd7, 1'b1, 5'd8, 1'b1, 128'h22);
        #1;
        n_cmp++; if (valids() !== V_LSU) begin n_err++; $display("FAIL raw_lw_issue: got %b want %b", valids(), V_LSU); end
        n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL raw_b2b_ready: got %b want 1", bus.s_dcd_ready); end
        tick();
        bus.s_dcd_valid = 1'b0;
        #1;
        n_cmp++; if (bus.pending_vec !== 32'h80) begin n_err++; $display("FAIL raw_pend: got %h want 80", bus.pending_vec); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL raw_stall: got %b want %b", valids(), V_NONE); end
        tick();
        bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd7;
        #1;
        n_cmp++; if (valids() !== (FWD ? V_ALU : V_NONE)) begin n_err++; $display("FAIL raw_wb_cycle: got %b want %b", valids(), FWD ? V_ALU : V_NONE); end
        tick();
        bus.lsu_wb_vld = 1'b0;
        #1;
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL raw_pend_clr: got %h want 0", bus.pending_vec); end
        n_cmp++; if (valids() !== (FWD ? V_NONE : V_ALU)) begin n_err++; $display("FAIL raw_after_wb: got %b want %b", valids(), FWD ? V_NONE : V_ALU); end
        n_cmp++; if (valids() == V_ALU && bus.m_pld !== 128'h22) begin n_err++; $display("FAIL raw_pld: got %h want 22", bus.m_pld); end
    endtask

    task automatic test_waw_stall();
        do_reset();
        present(T_DIV, 5'd0, 1'b0, 5'd3, 1'b1, 128'h33);
        tick();
        present(T_MUL, 5'd0, 1'b0, 5'd3, 1'b1, 128'h44);
        #1;
        n_cmp++; if (valids() !== V_DIV) begin n_err++; $display("FAIL waw_div_issue: got %b want %b", valids(), V_DIV); end
        tick();
        bus.s_dcd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (bus.pending_vec !== 32'h8) begin n_err++; $display("FAIL waw_pend: got %h want 8", bus.pending_vec); end
            n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL waw_stall: got %b want %b", valids(), V_NONE); end
            tick();
        end
        bus.md_wb_vld = 1'b1; bus.md_wb_rd = 5'd3;
        #1;
        n_cmp++; if (valids() !== (FWD ? V_MUL : V_NONE)) begin n_err++; $display("FAIL waw_wb_cycle: got %b want %b", valids(), FWD ? V_MUL : V_NONE); end
        tick();
        bus.md_wb_vld = 1'b0;
        #1;
        n_cmp++; if (bus.pending_vec !== (FWD ? 32'h8 : 32'h0)) begin n_err++; $display("FAIL waw_set_wins: got %h want %h", bus.pending_vec, FWD ? 32'h8 : 32'h0); end
        n_cmp++; if (valids() !== (FWD ? V_NONE : V_MUL)) begin n_err++; $display("FAIL waw_after_wb: got %b want %b", valids(), FWD ? V_NONE : V_MUL); end
        tick();
        n_cmp++; if (bus.pending_vec !== 32'h8) begin n_err++; $display("FAIL waw_reissue_pend: got %h want 8", bus.pending_vec); end
    endtask

    task automatic test_flush();
        do_reset();
        bus.m_csr_ready = 1'b0;
        present(T_CSR, 5'd1, 1'b1, 5'd2, 1'b1, 128'h55);
        tick();
        bus.s_dcd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (valids() !== V_CSR) begin n_err++; $display("FAIL flush_csr_hold: got %b want %b", valids(), V_CSR); end
            n_cmp++; if (bus.m_pld !== 128'h55) begin n_err++; $display("FAIL flush_csr_pld: got %h want 55", bus.m_pld); end
            tick();
        end
        bus.flush = 1'b1;
        present(T_ADD, 5'd0, 1'b0, 5'd6, 1'b1, 128'h66);
        #1;
        n_cmp++; if (bus.s_dcd_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", bus.s_dcd_ready); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL flush_valid: got %b want %b", valids(), V_NONE); end
        tick();
        bus.flush = 1'b0;
        bus.s_dcd_valid = 1'b0;
        bus.m_csr_ready = 1'b1;
        #1;
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL flush_dropped: got %b want %b", valids(), V_NONE); end
        n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL flush_empty: got %b want 1", bus.s_dcd_ready); end
        present(T_LW, 5'd0, 1'b0, 5'd9, 1'b1, 128'h77);
        tick();
        bus.s_dcd_valid = 1'b0;
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL flush_vs_issue: got %b want %b", valids(), V_NONE); end
        tick();
        bus.flush = 1'b0;
        #1;
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL flush_no_set: got %h want 0", bus.pending_vec); end
    endtask

    task automatic test_rd0_dual_clear();
        do_reset();
        present(T_LW, 5'd0, 1'b0, 5'd0, 1'b1, 128'h88);
        tick();
        bus.s_dcd_valid = 1'b0;
        #1;
        n_cmp++; if (valids() !== V_LSU) begin n_err++; $display("FAIL rd0_issue: got %b want %b", valids(), V_LSU); end
        tick();
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL rd0_pend: got %h want 0", bus.pending_vec); end
        present(T_LW, 5'd0, 1'b0, 5'd4, 1'b1, 128'h99);
        tick();
        present(T_DIV, 5'd0, 1'b0, 5'd9, 1'b1, 128'hAA);
        tick();
        bus.s_dcd_valid = 1'b0;
        tick();
        n_cmp++; if (bus.pending_vec !== 32'h210) begin n_err++; $display("FAIL dual_pend_set: got %h want 210", bus.pending_vec); end
        bus.lsu_wb_vld = 1'b1; bus.lsu_wb_rd = 5'd4;
        bus.md_wb_vld  = 1'b1; bus.md_wb_rd  = 5'd9;
        tick();
        bus.lsu_wb_vld = 1'b0; bus.md_wb_vld = 1'b0;
        #1;
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL dual_clear: got %h want 0", bus.pending_vec); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int r = 4; r < 8; r++) begin
            present(T_LW, 5'd0, 1'b0, 5'(r), 1'b1, 128'(r));
            #1;
            n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1 (rd %0d)", bus.s_dcd_ready, r); end
            tick();
        end
        present(T_ADD, 5'd4, 1'b1, 5'd10, 1'b1, 128'hBB);
        tick();
        bus.s_dcd_valid = 1'b0;
        tick();
        n_cmp++; if (bus.pending_vec !== 32'hF0) begin n_err++; $display("FAIL stall_pend: got %h want f0", bus.pending_vec); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL stall_valid: got %b want %b", valids(), V_NONE); end
        sys_rst = 1'b1;
        #1;
        n_cmp++; if (bus.s_dcd_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", bus.s_dcd_ready); end
        tick();
        n_cmp++; if (bus.pending_vec !== 32'h0) begin n_err++; $display("FAIL mid_rst_pend: got %h want 0", bus.pending_vec); end
        n_cmp++; if (valids() !== V_NONE) begin n_err++; $display("FAIL mid_rst_valid: got %b want %b", valids(), V_NONE); end
        sys_rst = 1'b0;
        #1;
        n_cmp++; if (bus.s_dcd_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready_after: got %b want 1", bus.s_dcd_ready); end
        n_cmp++; if (bus.m_pld !== 128'h0) begin n_err++; $display("FAIL mid_rst_pld: got %h want 0", bus.m_pld); end
    endtask

    // Reference model: one held instruction, a set of pending register numbers.
    task automatic test_random();
        bit           full_m;
        logic [6:0]   ht;
        logic [4:0]   h1, hd;
        bit           v1, vd;
        logic [127:0] hp;
        logic [31:0]  pm, cm, look;
        logic [4:0]   ev, rdy;
        bit           haz, fire, er;
        int           k;
        do_reset();
        full_m = 0; pm = '0; ht = '0; h1 = '0; hd = '0; v1 = 0; vd = 0; hp = '0;
        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 7);
            bus.s_dcd_valid   = ($urandom_range(0, 1) == 1);
            bus.s_dcd_type    = (k == 7) ? 7'd0 : 7'(1 << k);
            bus.s_dcd_pld     = {$urandom, $urandom, $urandom, $urandom};
            bus.s_dcd_rs1_id  = 5'($urandom_range(0, 7));
            bus.s_dcd_rs1_vld = ($urandom_range(0, 1) == 1);
            bus.s_dcd_rd_id   = 5'($urandom_range(0, 7));
            bus.s_dcd_rd_vld  = ($urandom_range(0, 3) != 0);
            bus.m_alu_ready   = ($urandom_range(0, 3) != 0);
            bus.m_lsu_ready   = ($urandom_range(0, 3) != 0);
            bus.m_csr_ready   = ($urandom_range(0, 3) != 0);
            bus.m_mul_ready   = ($urandom_range(0, 3) != 0);
            bus.m_div_ready   = ($urandom_range(0, 3) != 0);
            bus.lsu_wb_vld    = ($urandom_range(0, 2) == 0);
            bus.lsu_wb_rd     = 5'($urandom_range(0, 7));
            bus.md_wb_vld     = ($urandom_range(0, 2) == 0);
            bus.md_wb_rd      = 5'($urandom_range(0, 7));
            bus.flush         = ($urandom_range(0, 15) == 0);
            #1;
            cm = '0;
            if (bus.lsu_wb_vld) cm[bus.lsu_wb_rd] = 1'b1;
            if (bus.md_wb_vld)  cm[bus.md_wb_rd]  = 1'b1;
            look = FWD ? (pm & ~cm) : pm;
            haz  = (v1 && h1 != 0 && look[h1]) || (vd && hd != 0 && look[hd]);
            ev   = (full_m && !haz && !bus.flush) ? unit_of(ht) : V_NONE;
            rdy  = {bus.m_div_ready, bus.m_mul_ready, bus.m_csr_ready, bus.m_lsu_ready, bus.m_alu_ready};
            fire = |(ev & rdy);
            er   = !bus.flush && (!full_m || fire);
            n_cmp++; if (bus.s_dcd_ready !== er) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.s_dcd_ready, er); end
            n_cmp++; if (valids() !== ev) begin n_err++; $display("FAIL rnd_valids c%0d: got %b want %b", c, valids(), ev); end
            n_cmp++; if (bus.pending_vec !== pm) begin n_err++; $display("FAIL rnd_pend c%0d: got %h want %h", c, bus.pending_vec, pm); end
            if (ev != V_NONE) begin
                n_cmp++; if (bus.m_pld !== hp) begin n_err++; $display("FAIL rnd_pld c%0d: got %h want %h", c, bus.m_pld, hp); end
            end
            pm = pm & ~cm;
            if (fire && (ht[4] || ht[2] || ht[1] || ht[0]) && vd && hd != 0) pm[hd] = 1'b1;
            if (bus.flush) full_m = 0;
            else if (bus.s_dcd_valid && er) begin
                full_m = 1; ht = bus.s_dcd_type; hp = bus.s_dcd_pld;
                h1 = bus.s_dcd_rs1_id; v1 = bus.s_dcd_rs1_vld;
                hd = bus.s_dcd_rd_id;  vd = bus.s_dcd_rd_vld;
            end else if (fire) full_m = 0;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        sys_rst = 1'b1;
        idle_inputs();
        test_reset();
        test_alu();
        test_raw_stall();
        test_waw_stall();
        test_flush();
        test_rd0_dual_clear();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
